// File: rtl/instr_encoder.sv
// fifo: generic storage queue with registered occupancy and resettable storage.
// latency: a written entry is visible at the head on the cycle after the push.
// backpressure: push_rdy = !full from registered count; a pop never frees a slot in the same cycle.
module fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_vld,
    output logic         push_rdy,
    input  logic [W-1:0] push_dat,
    output logic         pop_vld,
    input  logic         pop_rdy,
    output logic [W-1:0] pop_dat
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;

    assign push_rdy = (count != CW'(DEPTH));
    assign pop_vld  = (count != '0);
    assign pop_dat  = mem[rd_ptr];
    assign push     = push_vld && push_rdy;
    assign pop      = pop_vld && pop_rdy;

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// instr_encoder: packs RV32I field requests into instruction words with a legality flag.
// latency: one cycle from an accepted request to the word at the FIFO head.
// backpressure: in_ready = FIFO not full; requests are held upstream while full.
module instr_encoder #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_class,
    input  logic [2:0]  in_funct3,
    input  logic        in_f7b5,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_err,
    output logic [7:0]  err_count
);
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    logic [31:0] enc_instr;
    logic        enc_err;
    logic        i_ok;
    logic        b_ok;
    logic        j_ok;
    logic        push;
    logic [32:0] head_dat;

    // An immediate fits an N-bit signed field when every bit above N-1 equals bit N-1.
    assign i_ok = (&in_imm[31:11]) | ~(|in_imm[31:11]);
    assign b_ok = (&in_imm[31:12]) | ~(|in_imm[31:12]);
    assign j_ok = (&in_imm[31:20]) | ~(|in_imm[31:20]);

    always_comb begin
        enc_instr = '0;
        enc_err   = 1'b0;
        case (in_class)
            4'd0: enc_instr = {1'b0, in_f7b5, 5'b0, in_rs2, in_rs1, in_funct3, in_rd, OPC_OP};
            4'd1: begin
                if (in_funct3[1:0] == 2'b01) begin
                    // funct3[2] separates SRLI/SRAI (101) from SLLI (001), which has no bit-30 variant.
                    enc_instr = {1'b0, in_funct3[2] & in_f7b5, 5'b0, in_imm[4:0],
                                 in_rs1, in_funct3, in_rd, OPC_OP_IMM};
                    enc_err   = |in_imm[31:5];
                end else begin
                    enc_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, OPC_OP_IMM};
                    enc_err   = !i_ok;
                end
            end
            4'd2: begin
                enc_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, OPC_LOAD};
                enc_err   = !i_ok || (in_funct3 == 3'b011) || (in_funct3[2:1] == 2'b11);
            end
            4'd3: begin
                enc_instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OPC_STORE};
                enc_err   = !i_ok || (in_funct3 >= 3'b011);
            end
            4'd4: begin
                enc_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                             in_imm[4:1], in_imm[11], OPC_BRANCH};
                enc_err   = !b_ok || in_imm[0] || (in_funct3[2:1] == 2'b01);
            end
            4'd5: begin
                enc_instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OPC_JAL};
                enc_err   = !j_ok || in_imm[0];
            end
            4'd6: begin
                enc_instr = {in_imm[11:0], in_rs1, 3'b000, in_rd, OPC_JALR};
                enc_err   = !i_ok;
            end
            4'd7: begin
                enc_instr = {in_imm[31:12], in_rd, OPC_LUI};
                enc_err   = |in_imm[11:0];
            end
            4'd8: begin
                enc_instr = {in_imm[31:12], in_rd, OPC_AUIPC};
                enc_err   = |in_imm[11:0];
            end
            default: enc_err = 1'b1;
        endcase
    end

    fifo #(.W(33), .DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (in_valid),
        .push_rdy (in_ready),
        .push_dat ({enc_err, enc_instr}),
        .pop_vld  (out_valid),
        .pop_rdy  (out_ready),
        .pop_dat  (head_dat)
    );

    assign {out_err, out_instr} = head_dat;
    assign push = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                   err_count <= '0;
        else if (push && enc_err && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
endmodule

// File: tb/tb_instr_encoder.sv
// Directed and randomized checks of instr_encoder against a field-level reference model.
module tb_instr_encoder;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_class;
    logic [2:0]  in_funct3;
    logic        in_f7b5;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;
    logic [7:0]  err_count;

    int          checks = 0;
    int          errors = 0;
    logic [32:0] q[$];
    logic [32:0] held;

    instr_encoder #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_class(in_class), .in_funct3(in_funct3), .in_f7b5(in_f7b5),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_err(out_err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    // Reference: field placement by shifted arithmetic, legality by signed range tests.
    function automatic logic [32:0] ref_enc(input logic [3:0] cls, input logic [2:0] f3,
                                            input logic f7, input logic [4:0] rd,
                                            input logic [4:0] rs1, input logic [4:0] rs2,
                                            input logic [31:0] imm);
        logic [31:0] u, w, rdf, f3f, r1f, r2f;
        int          s;
        bit          e;
        u   = imm;
        s   = $signed(imm);
        rdf = 32'(rd) << 7;
        f3f = 32'(f3) << 12;
        r1f = 32'(rs1) << 15;
        r2f = 32'(rs2) << 20;
        w   = 0;
        e   = 0;
        case (cls)
            0: w = 32'h33 | rdf | f3f | r1f | r2f | (32'(f7) << 30);
            1: if (f3 == 1 || f3 == 5) begin
                   w = 32'h13 | rdf | f3f | r1f | ((u % 32) << 20) | (32'((f3 == 5) && f7) << 30);
                   e = (u > 31);
               end else begin
                   w = 32'h13 | rdf | f3f | r1f | ((u & 32'hFFF) << 20);
                   e = !(s >= -2048 && s <= 2047);
               end
            2: begin
                w = 32'h03 | rdf | f3f | r1f | ((u & 32'hFFF) << 20);
                e = !(s >= -2048 && s <= 2047) || f3 == 3 || f3 == 6 || f3 == 7;
            end
            3: begin
                w = 32'h23 | ((u & 31) << 7) | f3f | r1f | r2f | (((u >> 5) & 127) << 25);
                e = !(s >= -2048 && s <= 2047) || f3 >= 3;
            end
            4: begin
                w = 32'h63 | (((u >> 11) & 1) << 7) | (((u >> 1) & 15) << 8) | f3f | r1f | r2f
                    | (((u >> 5) & 63) << 25) | (((u >> 12) & 1) << 31);
                e = !(s >= -4096 && s <= 4095) || (u % 2 == 1) || f3 == 2 || f3 == 3;
            end
            5: begin
                w = 32'h6F | rdf | (((u >> 12) & 255) << 12) | (((u >> 11) & 1) << 20)
                    | (((u >> 1) & 1023) << 21) | (((u >> 20) & 1) << 31);
                e = !(s >= -(1 << 20) && s < (1 << 20)) || (u % 2 == 1);
            end
            6: begin
                w = 32'h67 | rdf | r1f | ((u & 32'hFFF) << 20);
                e = !(s >= -2048 && s <= 2047);
            end
            7, 8: begin
                w = ((cls == 7) ? 32'h37 : 32'h17) | rdf | (u & 32'hFFFFF000);
                e = (u % 4096) != 0;
            end
            default: begin
                w = 0;
                e = 1;
            end
        endcase
        return {e, w};
    endfunction

    function automatic logic [31:0] rnd_imm();
        int v;
        case ($urandom_range(0, 5))
            0:       v = int'($urandom_range(0, 127)) - 64;
            1:       v = int'($urandom_range(0, 4097)) - 2049;
            2:       v = int'($urandom_range(0, 8193)) - 4097;
            3:       v = int'($urandom_range(0, (1 << 21) + 1)) - (1 << 20) - 1;
            4:       v = int'($urandom);
            default: v = int'($urandom & 32'hFFFFF000);
        endcase
        return v;
    endfunction

    task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int cls, input int f3, input int f7, input int rd,
                         input int rs1, input int rs2, input logic [31:0] imm);
        in_class  = 4'(cls);
        in_funct3 = 3'(f3);
        in_f7b5   = 1'(f7);
        in_rd     = 5'(rd);
        in_rs1    = 5'(rs1);
        in_rs2    = 5'(rs2);
        in_imm    = imm;
    endtask

    task automatic rnd_drive();
        in_class  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 8));
        in_funct3 = 3'($urandom);
        in_f7b5   = 1'($urandom);
        in_rd     = 5'($urandom);
        in_rs1    = 5'($urandom);
        in_rs2    = 5'($urandom);
        in_imm    = rnd_imm();
    endtask

    function automatic logic [32:0] ref_cur();
        return ref_enc(in_class, in_funct3, in_f7b5, in_rd, in_rs1, in_rs2, in_imm);
    endfunction

    task automatic push_cur();
        int n = 0;
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) chk("push_timeout", 33'(in_ready), 33'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        q.push_back(ref_cur());
    endtask

    task automatic pop_chk(input string tag, input logic [32:0] exp);
        int n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) chk({tag, "_timeout"}, 33'(out_valid), 33'd1);
        chk(tag, {out_err, out_instr}, exp);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic pop_model(input string tag);
        logic [32:0] e;
        e = q.pop_front();
        pop_chk(tag, e);
    endtask

    task automatic pop_const(input string tag, input logic [32:0] exp);
        q.delete(0);
        pop_chk(tag, exp);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_out_valid", 33'(out_valid), 33'd0);
        chk("rst_out", {out_err, out_instr}, 33'h0);
        chk("rst_err_count", 33'(err_count), 33'd0);
        chk("rst_in_ready", 33'(in_ready), 33'd1);

        // Directed encodings; the first also checks single-cycle latency.
        drive(1, 0, 0, 1, 0, 0, 32'd5); push_cur();
        chk("addi_latency", 33'(out_valid), 33'd1);
        pop_const("addi", 33'h0_00500093);
        drive(0, 0, 0, 3, 1, 2, 32'd0);  push_cur(); pop_const("add", 33'h0_002081B3);
        drive(0, 0, 1, 3, 1, 2, 32'd0);  push_cur(); pop_const("sub", 33'h0_402081B3);
        drive(3, 2, 0, 0, 1, 2, 32'd8);  push_cur(); pop_const("sw", 33'h0_0020A423);
        drive(4, 0, 0, 0, 1, 2, -32'sd4); push_cur(); pop_const("beq", 33'h0_FE208EE3);
        drive(5, 0, 0, 1, 0, 0, 32'd8);  push_cur(); pop_const("jal", 33'h0_008000EF);
        drive(7, 0, 0, 5, 0, 0, 32'h12345000); push_cur(); pop_const("lui", 33'h0_123452B7);

        // Error cases queued back to back.
        drive(9, 0, 0, 1, 1, 1, 32'd0);    push_cur();
        drive(4, 0, 0, 0, 1, 2, 32'd3);    push_cur();
        drive(1, 0, 0, 1, 0, 0, 32'd4096); push_cur();
        chk("err_count_3", 33'(err_count), 33'd3);
        pop_const("err_class9", 33'h1_00000000);
        pop_const("err_branch_odd", 33'h1_00208163);
        pop_const("err_addi_range", 33'h1_00000093);

        // Backpressure: fill, hold an extra request, then release one slot.
        for (int i = 0; i < DEPTH; i++) begin rnd_drive(); push_cur(); end
        chk("full_in_ready", 33'(in_ready), 33'd0);
        rnd_drive();
        held = ref_cur();
        in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("held_in_ready", 33'(in_ready), 33'd0);
        chk("held_head", {out_err, out_instr}, q[0]);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        q.delete(0);
        chk("ready_after_pop", 33'(in_ready), 33'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        q.push_back(held);
        chk("refull_in_ready", 33'(in_ready), 33'd0);
        for (int i = 0; i < DEPTH; i++) pop_model("bp_drain");
        chk("bp_empty", 33'(out_valid), 33'd0);

        // Continuous push and pop with two entries resident.
        rnd_drive(); push_cur();
        rnd_drive(); push_cur();
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            rnd_drive();
            in_valid = 1'b1;
            held = ref_cur();
            chk("stream_head", {out_err, out_instr}, q[0]);
            chk("stream_in_ready", 33'(in_ready), 33'd1);
            @(posedge clk); #1;
            q.delete(0);
            q.push_back(held);
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        pop_model("stream_tail0");
        pop_model("stream_tail1");
        chk("stream_empty", 33'(out_valid), 33'd0);

        // Randomized batches against the reference model.
        for (int b = 0; b < 40; b++) begin
            int n = $urandom_range(1, DEPTH);
            for (int i = 0; i < n; i++) begin rnd_drive(); push_cur(); end
            for (int i = 0; i < n; i++) pop_model("rand");
        end

        // Reset with entries queued, including one errored entry.
        drive(9, 0, 0, 0, 0, 0, 32'd0); push_cur();
        rnd_drive(); push_cur();
        rnd_drive(); push_cur();
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 33'(out_valid), 33'd0);
        chk("midrst_err_count", 33'(err_count), 33'd0);
        rnd_drive();
        in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        q.delete();
        chk("rst_ignores_in", 33'(out_valid), 33'd0);
        rnd_drive(); push_cur();
        chk("post_rst_vld", 33'(out_valid), 33'd1);
        pop_model("post_rst");
        chk("post_rst_alone", 33'(out_valid), 33'd0);

        // Saturation of the error counter.
        rst = 1'b1;
        #1 rst = 1'b0;
        q.delete();
        drive(12, 0, 0, 0, 0, 0, 32'd0);
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        repeat (253) @(posedge clk);
        #1;
        chk("err_count_254", 33'(err_count), 33'd254);
        repeat (46) @(posedge clk);
        #1;
        chk("err_count_sat", 33'(err_count), 33'd255);
        in_valid = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("sat_empty", 33'(out_valid), 33'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential RV32I instruction encoder: the inverse of the main decoder. It accepts field-level instruction requests (class, registers, funct bits, immediate) over a valid/ready handshake and packs them into 32-bit RV32I words. It range-checks each immediate and buffers results in a small FIFO. It feeds instruction-memory preload and self-test stimulus paths ahead of fetch and decode.

## Interface
- DEPTH, 4, output FIFO entries (power of two, ≥2)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  request present
- in_ready  out  1  encoder can accept (= FIFO not full)
- in_class  in  4  0 OP, 1 OP_IMM, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL, 6 JALR, 7 LUI, 8 AUIPC; 9–15 illegal
- in_funct3  in  3  funct3 field
- in_f7b5  in  1  instruction bit 30 (SUB/SRA/SRAI select)
- in_rd, in_rs1, in_rs2  in  5 each  register indices
- in_imm  in  32  full signed byte-offset / immediate value
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer takes head
- out_instr  out  32  encoded word at head
- out_err  out  1  head entry failed legality/range check
- err_count  out  8  saturating count of errored entries pushed

## Operation
- Push on in_valid && in_ready: encode combinationally, write {err, instr} into FIFO at the same edge. Pop on out_valid && out_ready.
- Opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111.
- OP: funct7 = {0, f7b5, 00000}, rs2, rs1, funct3, rd.
- OP_IMM: I-type. For funct3 001/101, bits[24:20] = imm[4:0] and bit30 = f7b5 (f7b5 forced 0 for 001). Otherwise imm[11:0] is used and f7b5 is ignored.
- LOAD/JALR: I-type. JALR funct3 forced 000.
- STORE: S-type {imm[11:5], rs2, rs1, f3, imm[4:0]}.
- BRANCH: B-type {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11]}.
- JAL: J-type {imm[20], imm[10:1], imm[11], imm[19:12], rd}.
- LUI/AUIPC: U-type {imm[31:12], rd}.
- Unused fields are zero.
- err = 1 when any of the following holds:
  - class ≥ 9;
  - LOAD funct3 ∈ {011, 110, 111};
  - STORE funct3 ≥ 011;
  - BRANCH funct3 ∈ {010, 011};
  - I/S imm is not a 12-bit sign extension;
  - shift imm[31:5] ≠ 0;
  - B imm is not a 13-bit sign extension or imm[0] = 1;
  - J imm is not a 21-bit sign extension or imm[0] = 1;
  - U imm[11:0] ≠ 0.
- Errored entries with an illegal class store instr = 0. All other errored entries store the word encoded from truncated bits.
- err_count increments on each errored push and saturates at 255.

## Timing
- Reset (asynchronous, immediate) and after reset:
  - out_valid = 0, out_instr = 0, out_err = 0, err_count = 0;
  - FIFO pointers and count = 0;
  - in_ready = 1.
- Latency: a push into an empty FIFO gives out_valid = 1 with the word on the next cycle. No combinational in→out path.
- in_ready = !full, derived from registered count only. When full, a simultaneous pop does not enable a push that cycle; in_ready rises the cycle after the pop.
- Simultaneous push and pop when not full: count unchanged, order preserved.
- Empty: out_instr/out_err hold the last-read storage value (don't-care), out_valid = 0, and pop is ignored.
- Pointers wrap modulo DEPTH. Count ranges 0..DEPTH.
- out_valid/out_instr are stable while out_valid && !out_ready.
- Reset mid-stream discards all entries. in_valid during reset is ignored.

## Test plan
- addi x1,x0,5 (class 1, f3 0, rd 1, rs1 0, imm 5) → 0x00500093, err 0, one cycle after push. add x3,x1,x2 → 0x002081B3; same request with f7b5 = 1 → 0x402081B3.
- sw x2,8(x1) → 0x0020A423. beq x1,x2,−4 → 0xFE208EE3. jal x1,8 → 0x008000EF. lui x5,0x12345000 → 0x123452B7.
- Errors, pushed in sequence:
  - class 9 → instr 0, err 1;
  - BRANCH imm 3 → err 1;
  - addi imm 4096 → err 1;
  - err_count = 3 after all three.
- Backpressure:
  - out_ready = 0 while pushing DEPTH+1 requests → in_ready falls after DEPTH pushes and the extra request is held;
  - then out_ready = 1 → words drain in order, and the held request is accepted the cycle after the first pop;
  - continuous push/pop holds count constant.
- Reset asserted with 3 entries queued → out_valid, err_count drop immediately; next push appears alone one cycle later.
- Saturation: 300 errored pushes → err_count stays 255.
